// File: rtl/charge_session_ctrl.sv
// Charging-bay session controller: converts coins into BCD M:SS credit and
// drives the countdown timer through load, run, pause-with-grace and done.
module charge_session_ctrl #(
  parameter int unsigned GRACE_CYCLES = 100,
  parameter int unsigned DONE_CYCLES  = 20,
  parameter logic [11:0] MAX_CREDIT   = 12'h959
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [2:0]  Coin,
  input  logic        CoinValid,
  input  logic        Plug,
  input  logic        Start,
  input  logic        Cancel,
  input  logic [11:0] PresentTime,
  input  logic        TimerZero,
  output logic [11:0] LoadValue,
  output logic        TimerLoad,
  output logic        ModeEnable,
  output logic [11:0] Credit,
  output logic        Charging,
  output logic        Done,
  output logic        Refund
);

  localparam int unsigned GW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam int unsigned DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_CHARGE,
    S_PAUSE,
    S_END
  } state_t;

  // {valid, BCD value}; unlisted codes decode as invalid
  function automatic logic [12:0] coin_decode(input logic [2:0] code);
    logic [12:0] r;
    case (code)
      3'b001:  r = {1'b1, 12'h030};
      3'b010:  r = {1'b1, 12'h100};
      3'b011:  r = {1'b1, 12'h230};
      3'b100:  r = {1'b1, 12'h500};
      default: r = 13'd0;
    endcase
    return r;
  endfunction

  function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  s, t, m;
    logic        c0, c1;
    logic [11:0] r;
    s  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    c0 = (s > 5'd9);
    if (c0) s = s - 5'd10;
    t  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, c0};
    c1 = (t > 5'd5);
    if (c1) t = t - 5'd6;
    m  = {1'b0, a[11:8]} + {1'b0, b[11:8]} + {4'd0, c1};
    r  = {m[3:0], t[3:0], s[3:0]};
    if ((m > 5'd9) || (r > MAX_CREDIT)) r = MAX_CREDIT;
    return r;
  endfunction

  state_t         state_q;
  logic [GW-1:0]  grace_q;
  logic [DW-1:0]  done_q;
  logic [11:0]    credit_q, load_q;
  logic           tload_q, mode_q, chg_q, done_flag_q, refund_q;

  logic [12:0]    coin_dec_d;
  logic           coin_ok_d;
  logic [11:0]    credit_sum_d, topup_d;
  logic           grace_last_d, done_last_d, end_req_d;

  assign coin_dec_d   = coin_decode(Coin);
  assign coin_ok_d    = CoinValid & coin_dec_d[12];
  assign credit_sum_d = bcd_add_sat(credit_q, coin_dec_d[11:0]);
  assign topup_d      = bcd_add_sat(PresentTime, coin_dec_d[11:0]);
  assign grace_last_d = (grace_q == GW'(GRACE_CYCLES - 2));
  assign done_last_d  = (done_q == DW'(DONE_CYCLES - 1));

  // TimerZero right after a load still reflects the old timer value, so it is masked
  assign end_req_d = ((state_q == S_CHARGE) && ((TimerZero && !tload_q) || Cancel)) ||
                     ((state_q == S_PAUSE) && (Cancel || (!Plug && grace_last_d)));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      grace_q     <= '0;
      done_q      <= '0;
      credit_q    <= 12'h000;
      load_q      <= 12'h000;
      tload_q     <= 1'b0;
      mode_q      <= 1'b0;
      chg_q       <= 1'b0;
      done_flag_q <= 1'b0;
      refund_q    <= 1'b0;
    end else begin
      tload_q  <= 1'b0;
      refund_q <= 1'b0;
      if (end_req_d) begin
        mode_q      <= 1'b0;
        chg_q       <= 1'b0;
        done_flag_q <= 1'b1;
        done_q      <= '0;
        state_q     <= S_END;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (coin_ok_d) begin
              credit_q <= coin_dec_d[11:0];
              state_q  <= S_CREDIT;
            end
          end
          S_CREDIT: begin
            if (Cancel) begin
              refund_q <= 1'b1;
              credit_q <= 12'h000;
              state_q  <= S_IDLE;
            end else if (Start && Plug) begin
              load_q   <= credit_q;
              tload_q  <= 1'b1;
              credit_q <= 12'h000;
              mode_q   <= 1'b1;
              chg_q    <= 1'b1;
              state_q  <= S_CHARGE;
            end else if (coin_ok_d) begin
              credit_q <= credit_sum_d;
            end
          end
          S_CHARGE: begin
            if (!Plug) begin
              mode_q  <= 1'b0;
              chg_q   <= 1'b0;
              grace_q <= '0;
              state_q <= S_PAUSE;
            end else if (coin_ok_d) begin
              load_q  <= topup_d;
              tload_q <= 1'b1;
            end
          end
          S_PAUSE: begin
            grace_q <= grace_q + 1'b1;
            if (Plug) begin
              mode_q  <= 1'b1;
              chg_q   <= 1'b1;
              state_q <= S_CHARGE;
            end
          end
          S_END: begin
            if (done_last_d) begin
              done_flag_q <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              done_q <= done_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign LoadValue  = load_q;
  assign TimerLoad  = tload_q;
  assign ModeEnable = mode_q;
  assign Credit     = credit_q;
  assign Charging   = chg_q;
  assign Done       = done_flag_q;
  assign Refund     = refund_q;

endmodule
